// File: rtl/ram_bist_if.sv
// RAM port bundle between the BIST initiator (master) and the RAM side (slave).
// Read data returns one clock after the address is presented with we=0.
`timescale 1ns/1ps
interface ram_bist_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output we, addr, din, input dout);
  modport slave  (input we, addr, din, output dout);
endinterface

// File: rtl/ram_bist.sv
// Three-phase March BIST for a single-port synchronous RAM: write P ascending,
// read P / write ~P ascending, read ~P descending; reports the first mismatch.
`timescale 1ns/1ps
module ram_bist #(
  parameter int                ADDR_W  = 2,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'h55)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  ram_bist_if.master        ram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [DATA_W-1:0] PAT_N = ~PATTERN;

  state_t            state;
  logic [1:0]        phase;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] exp_d;

  assign exp_d = (phase == 2'd1) ? PATTERN : PAT_N;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 2'd0;
      a         <= '0;
      ram.we    <= 1'b0;
      ram.addr  <= '0;
      ram.din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      done <= 1'b0;
      // DONE shares the launch path so a held start restarts on the edge leaving DONE
      if ((state == IDLE || state == DONE) && start) begin
        state     <= WR;
        phase     <= 2'd0;
        a         <= '0;
        ram.we    <= 1'b1;
        ram.addr  <= '0;
        ram.din   <= PATTERN;
        busy      <= 1'b1;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else begin
        case (state)
          IDLE: ;
          DONE: state <= IDLE;
          WR: begin
            ram.we  <= 1'b0;
            ram.din <= '0;
            state   <= RD;
            if (phase == 2'd0) begin
              if (a == LAST) begin
                phase    <= 2'd1;
                a        <= '0;
                ram.addr <= '0;
              end else begin
                state    <= WR;
                a        <= a + 1'b1;
                ram.we   <= 1'b1;
                ram.addr <= a + 1'b1;
                ram.din  <= PATTERN;
              end
            end else if (a == LAST) begin
              phase    <= 2'd2;
              a        <= LAST;
              ram.addr <= LAST;
            end else begin
              a        <= a + 1'b1;
              ram.addr <= a + 1'b1;
            end
          end
          RD: state <= CMP;
          CMP: begin
            if (ram.dout != exp_d) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              ram.addr  <= '0;
              pass      <= 1'b0;
              fail_addr <= a;
              fail_data <= ram.dout;
            end else if (phase == 2'd1) begin
              state   <= WR;
              ram.we  <= 1'b1;
              ram.din <= PAT_N;
            end else if (a == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              ram.addr <= '0;
              pass     <= 1'b1;
            end else begin
              state    <= RD;
              a        <= a - 1'b1;
              ram.addr <= a - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two instances (N=4 and N=8), each against a behavioural
// one-cycle-latency RAM with optional read-side fault injection.
`timescale 1ns/1ps
module tb_ram_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start = 1'b0;
  bit   sel   = 1'b0;
  int   fault_mode = 0, fault_addr = 0;

  ram_bist_if #(.ADDR_W(2), .DATA_W(8)) ra ();
  ram_bist_if #(.ADDR_W(3), .DATA_W(8)) rb ();

  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [1:0] fa_a;
  logic [2:0] fa_b;
  logic [7:0] fd_a, fd_b;
  logic       start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  ram_bist #(.ADDR_W(2), .DATA_W(8), .PATTERN(8'h55)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ram(ra), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail_addr(fa_a), .fail_data(fd_a));
  ram_bist #(.ADDR_W(3), .DATA_W(8), .PATTERN(8'h55)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ram(rb), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail_addr(fa_b), .fail_data(fd_b));

  // RAM models
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [8];
  logic [7:0] q_a, q_b;
  logic [1:0] rq_a;
  logic [2:0] rq_b;
  always @(posedge clk) begin
    if (ra.we) mem_a[ra.addr] <= ra.din;
    q_a  <= mem_a[ra.addr];
    rq_a <= ra.addr;
    if (rb.we) mem_b[rb.addr] <= rb.din;
    q_b  <= mem_b[rb.addr];
    rq_b <= rb.addr;
  end
  always_comb begin
    ra.dout = q_a;
    if (fault_mode == 1 && int'(rq_a) == fault_addr) ra.dout = q_a | 8'h01;
    if (fault_mode == 2 && int'(rq_a) == fault_addr) ra.dout = 8'h00;
    rb.dout = q_b;
    if (fault_mode == 1 && int'(rq_b) == fault_addr) rb.dout = q_b | 8'h01;
    if (fault_mode == 2 && int'(rq_b) == fault_addr) rb.dout = 8'h00;
  end

  // view of the selected instance
  logic       cur_busy, cur_done, cur_pass, cur_we;
  logic [2:0] cur_fa, cur_addr;
  logic [7:0] cur_fd, cur_din;
  always_comb begin
    cur_busy = sel ? busy_b : busy_a;
    cur_done = sel ? done_b : done_a;
    cur_pass = sel ? pass_b : pass_a;
    cur_we   = sel ? rb.we  : ra.we;
    cur_fa   = sel ? fa_b   : {1'b0, fa_a};
    cur_addr = sel ? rb.addr : {1'b0, ra.addr};
    cur_fd   = sel ? fd_b   : fd_a;
    cur_din  = sel ? rb.din : ra.din;
  end

  logic [10:0] wq [$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Pulse start, follow the run until done; dcyc = edges from acceptance to DONE.
  task automatic run(input bit mid, output int dcyc, output int bcnt);
    int e0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; e0 = cyc;
    bcnt = 0; dcyc = -1; wq.delete();
    for (int k = 0; k < 200 && dcyc < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (cur_busy) bcnt++;
      if (cur_we) wq.push_back({cur_addr, cur_din});
      if (cur_done) dcyc = cyc - e0;
      if (mid) start = (cyc - e0 == 5);
    end
    start = 1'b0;
  endtask

  typedef struct {
    bit sel; int mode; int faddr; bit mid; bit wr;
    int exp_done; int exp_busy; int exp_pass; int exp_fa; int exp_fd;
  } vec_t;
  vec_t vt [6];

  initial begin
    int d, b, d1, d2;
    bit hit;
    vt[0] = '{1'b0, 0, 0, 1'b0, 1'b1, 24, 24, 1, 0, 0};
    vt[1] = '{1'b0, 1, 2, 1'b0, 1'b0, 20, 20, 0, 2, 'hAB};
    vt[2] = '{1'b0, 2, 1, 1'b0, 1'b0,  9,  9, 0, 1, 0};
    vt[3] = '{1'b0, 0, 0, 1'b1, 1'b0, 24, 24, 1, 0, 0};
    vt[4] = '{1'b1, 0, 0, 1'b0, 1'b0, 48, 48, 1, 0, 0};
    vt[5] = '{1'b1, 2, 7, 1'b0, 1'b0, 31, 31, 0, 7, 0};

    // reset held with start toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = ~start;
      chk("reset_outs_a", int'(|{ra.we, ra.addr, ra.din, busy_a, done_a, pass_a, fa_a, fd_a}), 0);
      chk("reset_outs_b", int'(|{rb.we, rb.addr, rb.din, busy_b, done_b, pass_b, fa_b, fd_b}), 0);
    end
    @(negedge clk); start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", int'(|{ra.we, busy_a, done_a}), 0);

    for (int i = 0; i < 6; i++) begin
      sel = vt[i].sel; fault_mode = vt[i].mode; fault_addr = vt[i].faddr;
      run(vt[i].mid, d, b);
      chk($sformatf("v%0d_done_cycle", i), d, vt[i].exp_done);
      chk($sformatf("v%0d_busy_cycles", i), b, vt[i].exp_busy);
      chk($sformatf("v%0d_pass", i), int'(cur_pass), vt[i].exp_pass);
      chk($sformatf("v%0d_fail_addr", i), int'(cur_fa), vt[i].exp_fa);
      chk($sformatf("v%0d_fail_data", i), int'(cur_fd), vt[i].exp_fd);
      chk($sformatf("v%0d_done_drive", i), int'(|{cur_we, cur_addr, cur_din}), 0);
      if (vt[i].wr) begin
        chk("write_count", wq.size(), 8);
        for (int j = 0; j < wq.size() && j < 8; j++)
          chk($sformatf("write_%0d", j), int'(wq[j]),
              (j < 4) ? ((j << 8) | 'h55) : (((j - 4) << 8) | 'hAA));
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), int'(cur_done), 0);
      fault_mode = 0;
      @(negedge clk);
    end

    // reset mid-run during a phase-1 write
    sel = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (ra.we && ra.din == 8'hAA) hit = 1'b1;
    end
    chk("midrst_reached_wr", int'(hit), 1);
    rst = 1'b1;
    #1;
    chk("midrst_we", int'(ra.we), 0);
    chk("midrst_busy", int'(busy_a), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", int'(busy_a), 0);
    run(1'b0, d, b);
    chk("midrst_rerun_done", d, 24);
    chk("midrst_rerun_busy", b, 24);
    chk("midrst_rerun_pass", int'(pass_a), 1);
    @(negedge clk); @(negedge clk);

    // held start: back-to-back runs
    d1 = -1; d2 = -1;
    start = 1'b1;
    for (int k = 0; k < 120 && d2 < 0; k++) begin
      @(negedge clk);
      if (done_a) begin
        if (d1 < 0) d1 = cyc; else d2 = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_done_spacing", d2 - d1, 25);
    chk("b2b_pass", int'(pass_a), 1);
    @(negedge clk); @(negedge clk);
    chk("b2b_idle", int'(busy_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
